// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, matrix
// geometry and the one-hot-low column decoder.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    typedef struct packed {
        logic       one_hot;
        logic [1:0] idx;
    } col_dec_t;

    // Only a single low column is a real key; anything else is a ghost/multi-key.
    function automatic col_dec_t decode_cols(input logic [NUM_COLS-1:0] pat);
        col_dec_t d;
        d = '0;
        case (pat)
            4'b1110: d = '{one_hot: 1'b1, idx: 2'd0};
            4'b1101: d = '{one_hot: 1'b1, idx: 2'd1};
            4'b1011: d = '{one_hot: 1'b1, idx: 2'd2};
            4'b0111: d = '{one_hot: 1'b1, idx: 2'd3};
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for asynchronous inputs; resets to all-ones so an
// active-low bus reads as idle.
module keypad_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with debounce and one pulse per press.
// Optional KEYPAD_ACCUM_EN builds a 32-bit hex-digit shift accumulator.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// SCAN     | drive one row per SCAN_DIV cycles, look for any low column
// DEBOUNCE | row frozen, column pattern must stay stable DEBOUNCE_CNT cycles
// HELD     | key (or ghost) accepted, wait for DEBOUNCE_CNT idle cycles
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_in,
    output logic [NUM_ROWS-1:0] row_out,
    output logic                key_valid,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_held,
    output logic [31:0]         accum
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CNT - 1);

    logic [NUM_COLS-1:0] col_s;
    state_t              state_q, state_d;
    logic [1:0]          row_q, row_d;
    logic [SLOT_W-1:0]   slot_q, slot_d;
    logic [DEB_W-1:0]    cnt_q, cnt_d;
    logic [NUM_COLS-1:0] pat_q, pat_d;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                held_q, held_d;
    logic                valid_q, valid_d;
    col_dec_t            dec;

    keypad_sync #(.WIDTH(NUM_COLS)) u_col_sync (
        .clk (clk),
        .rst (rst),
        .d   (col_in),
        .q   (col_s)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCAN;
            row_q   <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            pat_q   <= '1;
            code_q  <= '0;
            held_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            slot_q  <= slot_d;
            cnt_q   <= cnt_d;
            pat_q   <= pat_d;
            code_q  <= code_d;
            held_q  <= held_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        slot_d  = slot_q;
        cnt_d   = cnt_q;
        pat_d   = pat_q;
        code_d  = code_q;
        held_d  = held_q;
        valid_d = 1'b0;
        dec     = decode_cols(pat_q);

        case (state_q)
            SCAN: begin
                if (slot_q == SLOT_LAST) begin
                    slot_d = '0;
                    if (col_s == '1) begin
                        row_d = row_q + 2'd1;
                    end else begin
                        pat_d   = col_s;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end
                end else begin
                    slot_d = slot_q + SLOT_W'(1);
                end
            end
            DEBOUNCE: begin
                if (col_s != pat_q) begin
                    cnt_d   = '0;
                    slot_d  = '0;
                    state_d = SCAN;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    state_d = HELD;
                    // Ghost patterns park in HELD silently until released.
                    if (dec.one_hot) begin
                        code_d  = {row_q, dec.idx};
                        valid_d = 1'b1;
                        held_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
            HELD: begin
                if (col_s != '1) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    cnt_d   = '0;
                    held_d  = 1'b0;
                    row_d   = row_q + 2'd1;
                    slot_d  = '0;
                    state_d = SCAN;
                end else begin
                    cnt_d = cnt_q + DEB_W'(1);
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
    end

    assign row_out   = ~(4'b0001 << row_q);
    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign key_held  = held_q;

`ifdef KEYPAD_ACCUM_EN
    logic [31:0] accum_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            accum_q <= '0;
        end else if (valid_q) begin
            accum_q <= {accum_q[31-CODE_W:0], code_q};
        end
    end

    assign accum = accum_q;
`else
    assign accum = 32'h0;
`endif

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Input-side counterpart to the multiplexed 7-segment output path: drives a 4x4 matrix keypad one row at a time, like the seg/sel digit scan, and reads the columns back.
- Synchronizes and debounces the columns, then reports one hex key code per press.
- Runs on the board clock beside the display driver. Its optional accumulator produces a 32-bit value that the top level can route to the display.

Parameters:
- SCAN_DIV, 4, clock cycles each row is driven; must be >= 3 so synchronized columns reflect the current row.
- DEBOUNCE_CNT, 8, consecutive stable cycles required to accept a press or a release; must be >= 1.

Ports:
- clk  input  1  board clock; every flop is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- col_in  input  4  keypad columns, active-low, pulled up; asynchronous to clk.
- row_out  output  4  row drive, active-low one-hot.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_code  output  4  {row[1:0], col[1:0]} of the last accepted key; held between presses.
- key_held  output  1  high while an accepted key is still down.
- accum  output  32  hex-digit accumulator (see Optional Feature).

Behaviour:
- Reset values (when rst is high at a clock edge): row_out=4'b1110, key_valid=0, key_code=0, key_held=0, accum=0, state=SCAN, all counters 0. A reset mid-operation aborts immediately and never emits a pulse.
- col_in passes through a 2-flop synchronizer. All decisions below use the synchronized value colS.
- Row index r is 2 bits; row_out = ~(4'b0001 << r).
- State SCAN:
  - The slot counter counts 0..SCAN_DIV-1.
  - At count SCAN_DIV-1, sample colS.
  - colS==4'hF: r <= r+1 (wraps 3->0), counter restarts.
  - Otherwise: latch colS into pat, clear the debounce counter, go to DEBOUNCE; r stays frozen.
- State DEBOUNCE:
  - Each cycle colS==pat: increment the counter.
  - Any mismatch: return to SCAN, restart the slot on the same r, no pulse.
  - Counter reaches DEBOUNCE_CNT with pat exactly one-hot-low: key_code <= {r, index of the low bit}, key_valid=1 for exactly that cycle, key_held <= 1, go to HELD.
  - Counter reaches DEBOUNCE_CNT with more than one bit low (ghost/multi-key): go to HELD with no pulse, key_held stays 0, key_code unchanged.
- State HELD:
  - r stays frozen.
  - The counter counts consecutive cycles with colS==4'hF; any low bit clears it.
  - At DEBOUNCE_CNT: key_held <= 0, r <= r+1, go to SCAN, slot counter 0.
- key_valid never asserts on two consecutive cycles. A new key is only accepted after a full release debounce.
- A single key held indefinitely produces one pulse.
- All counters are sized as $clog2 of their limit; no overflow is possible because each counter resets at its limit.

Optional Feature:
- Macro: KEYPAD_ACCUM_EN.
- Defined: on each key_valid cycle, accum <= {accum[27:0], key_code}, so the newest digit enters at the low nibble and the oldest drops off the top. accum is reset to 0 and is not affected by ghost presses.
- Not defined: the accumulator register is not built and accum is tied to 32'h0. The port is always present so the top level does not change.

Decomposition:
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, HELD);
  - constants NUM_ROWS=4, NUM_COLS=4, CODE_W=4;
  - the function that converts a one-hot-low column pattern to an index and a one-hot validity flag.
- Sub-module keypad_sync: a parameterized-width 2-flop synchronizer used for col_in. Reset is synchronous; its reset value is all-ones (idle).

Test Plan (SCAN_DIV=4, DEBOUNCE_CNT=8):
1. Reset: hold rst 2 cycles with col_in=4'h0 -> row_out=4'b1110, key_valid=0, key_code=0, key_held=0, accum=0.
2. Idle scan: col_in=4'hF for 32 cycles -> row_out steps 1110,1101,1011,0111 every 4 cycles, then wraps to 1110; key_valid stays 0.
3. Single press at row 2, col 1 (bench drives col_in=4'b1101 while row_out==4'b1011, held 60 cycles, then released) -> exactly one key_valid pulse with key_code=4'h9. key_held=1 from the pulse until 8 stable-release cycles; scanning then resumes with row_out=4'b0111.
4. Bounce: same key toggled every 3 cycles for 20 cycles, then held stable -> no pulse during the bounce; exactly one pulse, key_code=4'h9, after 8 stable cycles.
5. Ghost: col_in=4'b1001 on row 0 for 40 cycles -> no key_valid, key_held=0, key_code unchanged. After release, scanning resumes at row 1. Then assert rst in the middle of a HELD: outputs return to reset values the next cycle and no pulse appears.
6. Accumulator: press keys 1, 2, A in sequence (row 0 col 1; row 0 col 2; row 2 col 2) -> with KEYPAD_ACCUM_EN, accum=32'h0000012A; without the macro, accum=32'h0.
